proc_run_ctrl: RTL and testbench

Run/step controller for the 16-bit lab processor on the DE1-SoC. It sits between the board inputs (SW, KEY) and the processor's Run input. It replaces the fixed "release reset, then raise Run" bring-up sequence with a parametrised controller that adds:
- a reset hold-off
- free-run and single-step modes
- a PC breakpoint
- saturating cycle and instruction counters for the HEX/LEDR displays

---
 rtl/proc_ctrl_pkg.sv | 17 +
 rtl/proc_run_ctrl_key_pulse.sv | 53 +++++
 rtl/proc_run_ctrl.sv | 125 ++++++++++++
 tb/tb_proc_run_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/proc_ctrl_pkg.sv
// Shared state encoding and constants for the lab processor run/step controller.
package proc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST_HOLD = 3'd0,
    ST_IDLE     = 3'd1,
    ST_RUN      = 3'd2,
    ST_STEP     = 3'd3,
    ST_HALT     = 3'd4
  } run_state_e;

  // All-ones value of a width-bit counter, used as the saturation ceiling.
  function automatic logic [63:0] sat_max(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/proc_run_ctrl_key_pulse.sv
// Pushbutton conditioner: 2-FF synchroniser, stability debouncer and a
// one-cycle pulse on each debounced press (active-low key).
module key_pulse #(
  parameter int unsigned DB_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pulse
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The debounced level only follows the synced key after DB_CYCLES
  // consecutive disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    pulse_d = level_q & ~level_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/proc_run_ctrl.sv
// Run/step controller for the lab processor: reset hold-off, free-run and
// single-step modes, PC breakpoint and saturating cycle/instruction counters.
module proc_run_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned RST_HOLD  = 4,
  parameter int unsigned DB_CYCLES = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              run_sw,
  input  logic              step_mode,
  input  logic              step_key_n,
  input  logic              brk_en,
  input  logic [ADDR_W-1:0] brk_addr,
  input  logic [ADDR_W-1:0] pc,
  input  logic              done,
  input  logic              clr_cnt,
  output logic              Run,
  output logic              halted,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instr_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(sat_max(CNT_W));
  localparam logic [15:0]      HOLD_END = 16'(RST_HOLD);

  run_state_e       state_q, state_d;
  logic [2:0]       lvl_s1_q, lvl_s2_q;
  logic [15:0]      hold_q, hold_d;
  logic             run_q, run_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic             run_s, step_s, brk_s;
  logic             step_pulse;
  logic             brk_hit;

  key_pulse #(
    .DB_CYCLES (DB_CYCLES)
  ) u_step_key (
    .clk   (Clock),
    .rst_n (Resetn),
    .key_n (step_key_n),
    .pulse (step_pulse)
  );

  assign run_s   = lvl_s2_q[0];
  assign step_s  = lvl_s2_q[1];
  assign brk_s   = lvl_s2_q[2];
  assign brk_hit = brk_s && done && (pc == brk_addr);

  // Leaving RUN/STEP only happens on done, so a stop never cuts an instruction.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_RST_HOLD: begin
        if (hold_q == HOLD_END) state_d = ST_IDLE;
        else                    hold_d  = hold_q + 16'd1;
      end
      ST_IDLE: begin
        if (!step_s && run_s)          state_d = ST_RUN;
        else if (step_s && step_pulse) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (done) begin
          if (brk_hit)              state_d = ST_HALT;
          else if (!run_s || step_s) state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (done) state_d = brk_hit ? ST_HALT : ST_IDLE;
      end
      ST_HALT: begin
        if (!run_s) state_d = ST_IDLE;
      end
      default: state_d = ST_RST_HOLD;
    endcase
    run_d    = (state_d == ST_RUN) || (state_d == ST_STEP);
    halted_d = (state_d == ST_HALT);
  end

  always_comb begin
    cycle_d = cycle_q;
    instr_d = instr_q;
    if (clr_cnt) begin
      cycle_d = '0;
      instr_d = '0;
    end else begin
      if (run_q && (cycle_q != CNT_MAX)) cycle_d = cycle_q + 1'b1;
      if (run_q && done && (instr_q != CNT_MAX)) instr_d = instr_q + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= ST_RST_HOLD;
      lvl_s1_q <= '0;
      lvl_s2_q <= '0;
      hold_q   <= '0;
      run_q    <= 1'b0;
      halted_q <= 1'b0;
      cycle_q  <= '0;
      instr_q  <= '0;
    end else begin
      state_q  <= state_d;
      lvl_s1_q <= {brk_en, step_mode, run_sw};
      lvl_s2_q <= lvl_s1_q;
      hold_q   <= hold_d;
      run_q    <= run_d;
      halted_q <= halted_d;
      cycle_q  <= cycle_d;
      instr_q  <= instr_d;
    end
  end

  assign Run       = run_q;
  assign halted    = halted_q;
  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed self-checking bench for proc_run_ctrl with RST_HOLD=4,
// DB_CYCLES=8 and a 4-bit counter width so saturation is reachable.
module tb_proc_run_ctrl;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       run_sw;
  logic       step_mode;
  logic       step_key_n;
  logic       brk_en;
  logic [7:0] brk_addr;
  logic [7:0] pc;
  logic       done;
  logic       clr_cnt;
  logic       Run;
  logic       halted;
  logic [3:0] cycle_cnt;
  logic [3:0] instr_cnt;

  int num_checks = 0;
  int num_fails  = 0;

  proc_run_ctrl #(
    .RST_HOLD  (4),
    .DB_CYCLES (8),
    .ADDR_W    (8),
    .CNT_W     (4)
  ) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .run_sw     (run_sw),
    .step_mode  (step_mode),
    .step_key_n (step_key_n),
    .brk_en     (brk_en),
    .brk_addr   (brk_addr),
    .pc         (pc),
    .done       (done),
    .clr_cnt    (clr_cnt),
    .Run        (Run),
    .halted     (halted),
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
  );

  always #5 Clock = ~Clock;

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  // Drive the step key to a level and hold it for a number of edges.
  task automatic applyStimulus(input logic key_level, input int cycles);
    step_key_n = key_level;
    tick(cycles);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    assert (observed === expected)
    else begin
      num_fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    Resetn = 1'b0; run_sw = 1'b1; step_mode = 1'b0; step_key_n = 1'b1;
    brk_en = 1'b0; brk_addr = 8'h05; pc = 8'h00; done = 1'b0; clr_cnt = 1'b0;

    // Reset state and hold-off with run_sw already high
    tick(2);
    checkOutput("rst_run", Run, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_cycle", cycle_cnt, 0);
    checkOutput("rst_instr", instr_cnt, 0);
    Resetn = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      checkOutput($sformatf("holdoff_edge%0d", i), Run, 0);
    end
    tick(1);
    checkOutput("holdoff_run", Run, 1);
    checkOutput("holdoff_cycle0", cycle_cnt, 0);
    tick(1);
    checkOutput("holdoff_cycle1", cycle_cnt, 1);
    tick(1);
    checkOutput("holdoff_cycle2", cycle_cnt, 2);

    // Free-run: clear wins over increment, then done every third cycle
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    checkOutput("clr_cycle", cycle_cnt, 0);
    for (int k = 0; k < 3; k++) begin
      done = 1'b0;
      tick(2);
      done = 1'b1;
      tick(1);
      checkOutput($sformatf("free_instr%0d", k), instr_cnt, 32'(k + 1));
    end
    done = 1'b0;
    checkOutput("free_cycle9", cycle_cnt, 9);
    run_sw = 1'b0;
    tick(3);
    checkOutput("stop_midinstr", Run, 1);
    done = 1'b1;
    tick(1);
    checkOutput("stop_at_done", Run, 0);
    checkOutput("stop_instr", instr_cnt, 4);
    checkOutput("stop_cycle", cycle_cnt, 13);
    tick(2);
    done = 1'b0;
    checkOutput("idle_done_instr", instr_cnt, 4);
    checkOutput("idle_done_cycle", cycle_cnt, 13);

    // run_sw rising in IDLE reaches Run after the third edge
    run_sw = 1'b1;
    tick(2);
    checkOutput("rise_edge2", Run, 0);
    tick(1);
    checkOutput("rise_edge3", Run, 1);
    step_mode = 1'b1;
    run_sw = 1'b0;
    tick(3);
    checkOutput("mode_stop_wait", Run, 1);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    checkOutput("mode_stop_done", Run, 0);

    // Single-step: three presses, a short press glitch and a short release bounce
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    checkOutput("step_clr_instr", instr_cnt, 0);
    for (int p = 0; p < 3; p++) begin
      applyStimulus(1'b0, 10);
      checkOutput($sformatf("step%0d_pre", p), Run, 0);
      tick(1);
      checkOutput($sformatf("step%0d_run", p), Run, 1);
      tick(2);
      done = 1'b1;
      tick(1);
      done = 1'b0;
      checkOutput($sformatf("step%0d_end", p), Run, 0);
      if (p == 2) begin
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 14);
        checkOutput("release_bounce", Run, 0);
      end
      applyStimulus(1'b1, 12);
      if (p == 0) begin
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 14);
        checkOutput("press_glitch", Run, 0);
      end
    end
    checkOutput("step_instr", instr_cnt, 3);
    checkOutput("step_cycle", cycle_cnt, 9);

    // Breakpoint at pc 5 in free-run; cycle count saturates on the way
    step_mode = 1'b0;
    brk_en = 1'b1;
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    run_sw = 1'b1;
    tick(3);
    checkOutput("brk_start", Run, 1);
    for (int p = 0; p <= 5; p++) begin
      pc = 8'(p);
      tick(2);
      done = 1'b1;
      tick(1);
      done = 1'b0;
      checkOutput($sformatf("brk_run_pc%0d", p), Run, 32'(p != 5));
      checkOutput($sformatf("brk_halt_pc%0d", p), halted, 32'(p == 5));
    end
    checkOutput("brk_instr", instr_cnt, 6);
    checkOutput("brk_cycle_sat", cycle_cnt, 15);
    done = 1'b1;
    tick(2);
    done = 1'b0;
    checkOutput("halt_done_instr", instr_cnt, 6);
    checkOutput("halt_hold", halted, 1);
    run_sw = 1'b0;
    tick(2);
    checkOutput("halt_wait", halted, 1);
    tick(1);
    checkOutput("halt_clear", halted, 0);
    brk_en = 1'b0;
    pc = 8'h00;

    // Saturation of both counters and clear during an increment
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    run_sw = 1'b1;
    tick(3);
    checkOutput("sat_start", cycle_cnt, 0);
    tick(20);
    checkOutput("sat_cycle", cycle_cnt, 15);
    tick(2);
    checkOutput("sat_cycle_hold", cycle_cnt, 15);
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    checkOutput("sat_clr", cycle_cnt, 0);
    tick(2);
    checkOutput("sat_resume", cycle_cnt, 2);
    done = 1'b1;
    tick(18);
    done = 1'b0;
    checkOutput("sat_instr", instr_cnt, 15);

    // Asynchronous reset in the middle of RUN
    #2;
    Resetn = 1'b0;
    #1;
    checkOutput("async_run", Run, 0);
    checkOutput("async_cycle", cycle_cnt, 0);
    checkOutput("async_instr", instr_cnt, 0);
    tick(2);
    Resetn = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      checkOutput($sformatf("rehold_edge%0d", i), Run, 0);
    end
    tick(1);
    checkOutput("rehold_run", Run, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
